execute_stage: RTL

Final pipeline stage of each threadbrain core, directly downstream of the register-select stage. It consumes the gated instruction and resolved cell value from select and retires each instruction:
- PLUS/MINUS results are written back into the register cache, which releases the lock.
- BRZ is resolved into a branch pulse back to fetch and select.
- PRINT characters are buffered in a small FIFO feeding the console port.

---
 rtl/execute_stage.sv | 68 ++++++
 1 files changed

// File: rtl/execute_stage.sv
// execute_stage: retires PLUS/MINUS as register-cache writebacks, resolves BRZ,
// and buffers PRINT characters in a small FIFO for the console.
module execute_stage #(
  parameter int PRINT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ins,
  input  logic [15:0] ptr,
  input  logic [15:0] val,
  output logic        wb_en,
  output logic [15:0] wb_tag,
  output logic [15:0] wb_val,
  output logic        branch_en,
  output logic [15:0] branch_target,
  output logic        ex_stall,
  output logic        print_valid,
  output logic [7:0]  print_data,
  input  logic        print_ready,
  output logic [31:0] retired
);
  localparam int AW = $clog2(PRINT_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(PRINT_DEPTH);
  logic [3:0]    op;
  logic [15:0]   imm;
  logic          is_plus, is_minus, is_brz, is_print, push, pop;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [7:0]    mem [PRINT_DEPTH];
  assign op          = ins[15:12];
  assign imm         = {4'h0, ins[11:0]};
  assign is_plus     = op == 4'h1;
  assign is_minus    = op == 4'h2;
  assign is_brz      = op == 4'h5;
  assign is_print    = op == 4'h8;
  assign ex_stall    = is_print && count == FULL;
  assign push        = is_print && !ex_stall;
  assign pop         = print_valid && print_ready;
  assign print_valid = count != '0;
  // Gate the head with valid so stale or never-written entries read as zero.
  assign print_data  = print_valid ? mem[rd_ptr] : 8'h00;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_en         <= 1'b0;
      wb_tag        <= '0;
      wb_val        <= '0;
      branch_en     <= 1'b0;
      branch_target <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      retired       <= '0;
    end else begin
      wb_en     <= is_plus || is_minus;
      branch_en <= is_brz && val == 16'h0000;
      if (is_plus || is_minus) begin
        wb_tag <= ptr;
        wb_val <= is_plus ? val + imm : val - imm;
      end
      if (is_brz && val == 16'h0000) branch_target <= imm;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count   <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      retired <= retired + 32'(ins != 16'h0000 && !ex_stall);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= val[7:0];
endmodule
